v_alu_seq: RTL and testbench

- Controller that executes one whole-vector-register ALU instruction on the shared 32-bit VALU.
- Splits VECTOR_LENGTH-bit operands into 32-bit chunks and issues the chunks one at a time.
- Waits a fixed ALU latency per chunk, then reassembles the result.
- Elements at index >= vl keep their old destination value (tail-undisturbed).
- Sits between vector issue/decode logic and v_alu.

---
 rtl/v_alu_if.sv | 28 ++
 rtl/v_alu_seq.sv | 214 +++++++++++++++++++++
 tb/tb_v_alu_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/v_alu_if.sv
// Bus between the vector ALU sequencer and the shared 32-bit VALU.
// master drives operands and opcode; slave returns the chunk result.
interface v_alu_if #(
  parameter int unsigned OP_INSTR_W    = 6,
  parameter int unsigned VALU_OP_W_MAX = 32
);
  logic [OP_INSTR_W-1:0]    alu_op_instr;
  logic [1:0]               alu_vsew;
  logic [VALU_OP_W_MAX-1:0] alu_op_A;
  logic [VALU_OP_W_MAX-1:0] alu_op_B;
  logic [VALU_OP_W_MAX-1:0] alu_result;

  modport master (
    output alu_op_instr,
    output alu_vsew,
    output alu_op_A,
    output alu_op_B,
    input  alu_result
  );

  modport slave (
    input  alu_op_instr,
    input  alu_vsew,
    input  alu_op_A,
    input  alu_op_B,
    output alu_result
  );
endinterface

// File: rtl/v_alu_seq.sv
// Runs one whole-register vector ALU instruction on the 32-bit VALU, one chunk
// at a time, and reassembles the result with tail-undisturbed merging.
module v_alu_seq #(
  parameter int unsigned VECTOR_LENGTH = 128,
  parameter int unsigned VALU_OP_W_MAX = 32,
  parameter int unsigned OP_INSTR_W    = 6,
  parameter int unsigned ALU_LAT       = 1,
  parameter int unsigned VL_W          = $clog2(VECTOR_LENGTH/8) + 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     start,
  input  logic [OP_INSTR_W-1:0]    op_instr,
  input  logic [1:0]               vsew,
  input  logic [VL_W-1:0]          vl,
  input  logic [VECTOR_LENGTH-1:0] vs1,
  input  logic [VECTOR_LENGTH-1:0] vs2,
  input  logic [VECTOR_LENGTH-1:0] vd_old,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [VECTOR_LENGTH-1:0] vd_result,
  v_alu_if.master                  alu
);

  localparam int unsigned CHUNKS = VECTOR_LENGTH / VALU_OP_W_MAX;
  localparam int unsigned BPC    = VALU_OP_W_MAX / 8;
  localparam int unsigned CNT_W  = $clog2(CHUNKS + 1);
  localparam int unsigned CIDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned LAT_W  = $clog2(ALU_LAT + 2);
  localparam int unsigned BYTE_W = VL_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [OP_INSTR_W-1:0]    op_q, op_d;
  logic [1:0]               vsew_q, vsew_d;
  logic [VL_W-1:0]          vl_q, vl_d;
  logic [CNT_W-1:0]         n_q, n_d;
  logic [CNT_W-1:0]         chunk_q, chunk_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [VECTOR_LENGTH-1:0] vs1_q, vs1_d;
  logic [VECTOR_LENGTH-1:0] vs2_q, vs2_d;
  logic [VALU_OP_W_MAX-1:0] alu_a_q, alu_a_d;
  logic [VALU_OP_W_MAX-1:0] alu_b_q, alu_b_d;
  logic [CHUNKS-1:0][VALU_OP_W_MAX-1:0] vd_result_q, vd_result_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic [VL_W-1:0]          vlmax_c;
  logic [VL_W-1:0]          vl_clamp_c;
  logic [BYTE_W-1:0]        bytes_c;
  logic [CNT_W-1:0]         n_c;
  logic                     skip_c;
  logic [CIDX_W-1:0]        chunk_idx_c;
  logic [VALU_OP_W_MAX-1:0] merged_c;
  logic                     last_chunk_c;

  // Length of the incoming request: clamp vl to VLMAX and count 32-bit chunks.
  always_comb begin : len_calc
    vlmax_c    = VL_W'(VECTOR_LENGTH / 8) >> vsew;
    vl_clamp_c = (vl > vlmax_c) ? vlmax_c : vl;
    bytes_c    = BYTE_W'(vl_clamp_c) << vsew;
    n_c        = CNT_W'((bytes_c + BYTE_W'(BPC - 1)) >> $clog2(BPC));
    skip_c     = (vsew == 2'd3) || (vl == '0);
  end

  // Tail merge: vd_result was seeded with vd_old, so tail bytes keep their value.
  always_comb begin : chunk_merge
    int unsigned gb;
    int unsigned elem;
    chunk_idx_c = CIDX_W'(chunk_q);
    merged_c    = vd_result_q[chunk_idx_c];
    gb          = 0;
    elem        = 0;
    for (int unsigned b = 0; b < BPC; b++) begin
      gb   = 32'(chunk_q) * BPC + b;
      elem = gb >> vsew_q;
      if (elem < 32'(vl_q)) begin
        merged_c[b*8 +: 8] = alu.alu_result[b*8 +: 8];
      end
    end
    last_chunk_c = (CNT_W'(chunk_q + CNT_W'(1)) == n_q);
  end

  // Sequencer FSM: IDLE -> EXEC -> DONE -> IDLE.
  always_comb begin : next_state
    state_d     = state_q;
    op_d        = op_q;
    vsew_d      = vsew_q;
    vl_d        = vl_q;
    n_d         = n_q;
    chunk_d     = chunk_q;
    lat_d       = lat_q;
    vs1_d       = vs1_q;
    vs2_d       = vs2_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    vd_result_d = vd_result_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d        = op_instr;
          vsew_d      = vsew;
          vl_d        = vl_clamp_c;
          n_d         = n_c;
          chunk_d     = '0;
          lat_d       = '0;
          vd_result_d = vd_old;
          if (skip_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = (vsew == 2'd3);
            busy_d  = 1'b0;
            alu_a_d = '0;
            alu_b_d = '0;
          end else begin
            state_d = S_EXEC;
            busy_d  = 1'b1;
            alu_a_d = vs1[VALU_OP_W_MAX-1:0];
            alu_b_d = vs2[VALU_OP_W_MAX-1:0];
            vs1_d   = vs1 >> VALU_OP_W_MAX;
            vs2_d   = vs2 >> VALU_OP_W_MAX;
          end
        end
      end

      S_EXEC: begin
        if (lat_q == LAT_W'(ALU_LAT)) begin
          vd_result_d[chunk_idx_c] = merged_c;
          lat_d                    = '0;
          if (last_chunk_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            alu_a_d = '0;
            alu_b_d = '0;
          end else begin
            // Remaining operand chunks are kept right-aligned in vs1_q/vs2_q.
            chunk_d = CNT_W'(chunk_q + CNT_W'(1));
            alu_a_d = vs1_q[VALU_OP_W_MAX-1:0];
            alu_b_d = vs2_q[VALU_OP_W_MAX-1:0];
            vs1_d   = vs1_q >> VALU_OP_W_MAX;
            vs2_d   = vs2_q >> VALU_OP_W_MAX;
          end
        end else begin
          lat_d = LAT_W'(lat_q + LAT_W'(1));
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      vsew_q      <= '0;
      vl_q        <= '0;
      n_q         <= '0;
      chunk_q     <= '0;
      lat_q       <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      vd_result_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      vsew_q      <= vsew_d;
      vl_q        <= vl_d;
      n_q         <= n_d;
      chunk_q     <= chunk_d;
      lat_q       <= lat_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      vd_result_q <= vd_result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign vd_result        = vd_result_q;
  assign alu.alu_op_instr = op_q;
  assign alu.alu_vsew     = vsew_q;
  assign alu.alu_op_A     = alu_a_q;
  assign alu.alu_op_B     = alu_b_q;

endmodule

// File: tb/tb_v_alu_seq.sv
// Scoreboard bench for v_alu_seq with a one-cycle-latency VALU model.
module tb_v_alu_seq;

  localparam logic [5:0] OP_VADD = 6'd0;
  localparam logic [5:0] OP_VSUB = 6'd1;
  localparam logic [5:0] OP_VAND = 6'd2;

  logic         clk = 1'b0;
  logic         nrst;
  logic         start;
  logic [5:0]   op_instr;
  logic [1:0]   vsew;
  logic [4:0]   vl;
  logic [127:0] vs1, vs2, vd_old;
  logic         busy, done, err;
  logic [127:0] vd_result;
  logic [31:0]  alu_res;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int issue_cnt = 0;

  typedef struct {
    string        name;
    logic [127:0] vd;
    logic         err;
    int           done_cyc;
    int           issues;
  } exp_t;
  exp_t sb[$];

  v_alu_if #(.OP_INSTR_W(6), .VALU_OP_W_MAX(32)) alu_bus ();

  v_alu_seq #(
    .VECTOR_LENGTH(128), .VALU_OP_W_MAX(32), .OP_INSTR_W(6), .ALU_LAT(1)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .op_instr(op_instr),
    .vsew(vsew), .vl(vl), .vs1(vs1), .vs2(vs2), .vd_old(vd_old),
    .busy(busy), .done(done), .err(err), .vd_result(vd_result),
    .alu(alu_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [1:0] sew,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, mask, ea, eb, er;
    int w;
    w    = (sew == 2'd3) ? 32 : (8 << sew);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r    = '0;
    for (int i = 0; i < 32; i += w) begin
      ea = (a >> i) & mask;
      eb = (b >> i) & mask;
      case (op)
        OP_VADD: er = ea + eb;
        OP_VSUB: er = ea - eb;
        default: er = ea & eb;
      endcase
      r = r | ((er & mask) << i);
    end
    return r;
  endfunction

  // VALU model: result valid one cycle after operands are presented.
  always @(posedge clk)
    alu_res <= alu_f(alu_bus.alu_op_instr, alu_bus.alu_vsew, alu_bus.alu_op_A, alu_bus.alu_op_B);
  assign alu_bus.alu_result = alu_res;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT signals done.
  always @(negedge clk) begin
    exp_t e;
    if (!nrst) begin
      issue_cnt = 0;
    end else begin
      if (alu_bus.alu_op_A != 32'd0) issue_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 128'(done), 128'(0));
        end else begin
          e = sb.pop_front();
          check({e.name, "_vd"}, vd_result, e.vd);
          check({e.name, "_err"}, 128'(err), 128'(e.err));
          check({e.name, "_lat"}, 128'(cyc), 128'(e.done_cyc));
          check({e.name, "_issue"}, 128'(issue_cnt), 128'(e.issues));
        end
        issue_cnt = 0;
      end
    end
  end

  task automatic issue(input string name, input logic [5:0] op, input logic [1:0] sew,
                       input logic [4:0] l, input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] old, input logic [127:0] exp_vd,
                       input logic exp_err, input int lat, input int iss);
    exp_t e;
    op_instr = op; vsew = sew; vl = l; vs1 = a; vs2 = b; vd_old = old;
    start = 1'b1;
    e.name = name; e.vd = exp_vd; e.err = exp_err; e.done_cyc = cyc + lat; e.issues = iss;
    sb.push_back(e);
    @(posedge clk); #1;
    start    = 1'b0;
    op_instr = 6'($urandom);
    vsew     = 2'($urandom);
    vl       = 5'($urandom);
    vs1      = {$urandom, $urandom, $urandom, $urandom};
    vs2      = {$urandom, $urandom, $urandom, $urandom};
    vd_old   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    while (sb.size() != 0 && k < maxc) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (sb.size() != 0) begin
      check("drain_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_err"}, 128'(err), 128'(0));
    check({tag, "_vd"}, vd_result, 128'(0));
    check({tag, "_opA"}, 128'(alu_bus.alu_op_A), 128'(0));
    check({tag, "_opB"}, 128'(alu_bus.alu_op_B), 128'(0));
    check({tag, "_instr"}, 128'(alu_bus.alu_op_instr), 128'(0));
    check({tag, "_vsew"}, 128'(alu_bus.alu_vsew), 128'(0));
  endtask

  initial begin
    int k;
    nrst = 1'b0; start = 1'b0; op_instr = '0; vsew = '0; vl = '0;
    vs1 = '0; vs2 = '0; vd_old = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    nrst = 1'b1;
    @(posedge clk); #1;

    issue("vadd8", OP_VADD, 2'd0, 5'd16, {16{8'h7F}}, {16{8'h01}}, {16{8'h55}},
          {16{8'h80}}, 1'b0, 9, 8);
    wait_drain(30);
    issue("vsub16", OP_VSUB, 2'd1, 5'd3, {8{16'h0005}}, {8{16'h0007}}, {8{16'hAAAA}},
          128'hAAAA_AAAA_AAAA_AAAA_AAAA_FFFE_FFFE_FFFE, 1'b0, 5, 4);
    wait_drain(30);
    issue("vl0", OP_VAND, 2'd2, 5'd0, {4{32'hFFFF0000}}, {4{32'h0F0F0F0F}},
          128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
          128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 1, 0);
    wait_drain(30);
    issue("sew3", OP_VADD, 2'd3, 5'd4, {4{32'h1}}, {4{32'h2}},
          128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0,
          128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 1'b1, 1, 0);
    wait_drain(30);
    issue("vand32_vl2", OP_VAND, 2'd2, 5'd2, {4{32'hF0F0F0F0}}, {4{32'h3C3C3C3C}},
          {4{32'h11111111}}, 128'h11111111_11111111_30303030_30303030, 1'b0, 5, 4);
    wait_drain(30);
    issue("vadd8_vl5", OP_VADD, 2'd0, 5'd5, {16{8'h01}}, {16{8'h02}}, {16{8'hCC}},
          128'hCCCCCCCC_CCCCCCCC_CCCCCC03_03030303, 1'b0, 5, 4);
    wait_drain(30);

    // Clamped vl, start pulses while busy, then a start right after done.
    issue("clamp20", OP_VADD, 2'd0, 5'd20, {16{8'h10}}, {16{8'h22}}, 128'd0,
          {16{8'h32}}, 1'b0, 9, 8);
    for (int p = 0; p < 3; p++) begin
      @(posedge clk); #1;
      start = 1'b1; vl = 5'd1; vsew = 2'd2; vs1 = {4{32'h5A5A5A5A}};
      @(posedge clk); #1;
      start = 1'b0;
    end
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("b2b_done_seen", 128'(done), 128'(1));
    @(posedge clk); #1;
    issue("b2b_vsub32", OP_VSUB, 2'd2, 5'd4, {4{32'h10}}, {4{32'h1}}, '1,
          {4{32'h0000000F}}, 1'b0, 9, 8);
    wait_drain(30);

    // Reset during chunk 2 of a 4-chunk op: discarded, no done.
    issue("aborted", OP_VADD, 2'd0, 5'd16, 128'h04040404_03030303_02020202_01010101,
          128'd0, 128'd0, 128'd0, 1'b0, 9, 8);
    repeat (4) @(posedge clk);
    #2;
    check("chunk2_opA", 128'(alu_bus.alu_op_A), 128'(32'h03030303));
    nrst = 1'b0;
    #1;
    check_zero("midrst");
    sb.delete();
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    issue("after_rst", OP_VSUB, 2'd0, 5'd16, {16{8'h05}}, {16{8'h03}}, 128'd0,
          {16{8'h02}}, 1'b0, 9, 8);
    wait_drain(30);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
